// File: rtl/gray_sweep_controller.sv
// rtl/gray_sweep_controller.sv - command-driven Gray-code sweep sequencer
// Accepts one sweep command at a time and streams gray(b) for each beat.
module gray_sweep_controller #(
  parameter int WIDTH     = 4,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_start,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 cmd_dir,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     gray_out,
  output logic [WIDTH-1:0]     binary_out,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     b;
  logic [LEN_WIDTH-1:0] rem;
  logic                 dir;
  logic                 aborted_q;

  assign cmd_ready  = (state == S_IDLE);
  assign out_valid  = (state == S_RUN);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign aborted    = aborted_q;
  assign binary_out = b;
  assign gray_out   = b ^ (b >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      b         <= '0;
      rem       <= '0;
      dir       <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            b     <= cmd_start;
            rem   <= cmd_len;
            dir   <= cmd_dir;
            state <= (cmd_len != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          // Abort wins over completion; a beat taken alongside abort still counts.
          if (abort) begin
            state     <= S_IDLE;
            aborted_q <= 1'b1;
          end else if (out_ready) begin
            if (rem == LEN_WIDTH'(1)) begin
              state <= S_DONE;
            end else begin
              rem <= rem - LEN_WIDTH'(1);
              b   <= dir ? (b - WIDTH'(1)) : (b + WIDTH'(1));
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_sweep_controller.sv
// tb/tb_gray_sweep_controller.sv - randomized self-checking bench for gray_sweep_controller
// Expected beats come from start +/- k modulo 2^W, independent of the RTL state machine.
module tb_gray_sweep_controller;

  localparam int W  = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_start;
  logic [LW-1:0] cmd_len;
  logic          cmd_dir;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  gray_out;
  logic [W-1:0]  binary_out;
  logic          busy;
  logic          done;
  logic          aborted;

  int checks   = 0;
  int failures = 0;
  int ready_prob = 100;
  bit rdy_pat[$];

  gray_sweep_controller #(.WIDTH(W), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_dir(cmd_dir),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .gray_out(gray_out), .binary_out(binary_out),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sweep_val(input int start, input int dir, input int k);
    return dir != 0 ? ((start - k) & ((1 << W) - 1)) : ((start + k) & ((1 << W) - 1));
  endfunction

  function automatic int to_gray(input int x);
    return (x ^ (x >> 1)) & ((1 << W) - 1);
  endfunction

  function automatic bit next_ready();
    if (rdy_pat.size() != 0) return rdy_pat.pop_front();
    return $urandom_range(99, 0) < ready_prob;
  endfunction

  // Starts just after a negedge with the command inputs idle; ends the same way.
  task automatic run_sweep(input int start, input int len, input int dir, input int abort_at);
    int k;
    int cyc;
    bit rdy;
    bit ab;
    bit fin;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("cmd_ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_start = W'(start);
    cmd_len   = LW'(len);
    cmd_dir   = dir[0];
    abort     = 1'($urandom_range(1, 0));
    out_ready = 1'($urandom_range(1, 0));
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cmd_start = W'($urandom);
    cmd_len   = LW'($urandom);
    cmd_dir   = 1'($urandom);
    if (len == 0) begin
      check("zero_out_valid", int'(out_valid), 0);
      check("zero_done", int'(done), 1);
      check("zero_cmd_ready_t1", int'(cmd_ready), 0);
      cmd_valid = 1'b1;
      cmd_len   = LW'(3);
      abort     = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      abort     = 1'b0;
      check("zero_cmd_ready_t2", int'(cmd_ready), 1);
      check("zero_done_t2", int'(done), 0);
      check("zero_aborted_t2", int'(aborted), 0);
      check("zero_no_accept_in_done", int'(out_valid), 0);
      @(negedge clk);
      check("zero_still_idle", int'(busy), 0);
      return;
    end
    k   = 0;
    fin = 1'b0;
    cyc = 0;
    while (!fin) begin
      check("beat_valid", int'(out_valid), 1);
      check("beat_gray", int'(gray_out), to_gray(sweep_val(start, dir, k)));
      check("beat_binary", int'(binary_out), sweep_val(start, dir, k));
      check("beat_no_done", int'(done), 0);
      rdy = next_ready();
      out_ready = rdy;
      ab = (abort_at != 0) && rdy && (k + 1 == abort_at);
      abort = ab;
      if (rdy) k++;
      @(negedge clk);
      cyc++;
      abort = 1'b0;
      if (ab) begin
        check("abort_pulse", int'(aborted), 1);
        check("abort_cmd_ready", int'(cmd_ready), 1);
        check("abort_no_done", int'(done), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_beats", k, abort_at);
        @(negedge clk);
        check("abort_pulse_once", int'(aborted), 0);
        check("abort_no_late_done", int'(done), 0);
        fin = 1'b1;
      end else if (k == len) begin
        check("done_pulse", int'(done), 1);
        check("done_out_valid", int'(out_valid), 0);
        check("done_cmd_ready", int'(cmd_ready), 0);
        check("done_busy", int'(busy), 1);
        check("done_no_aborted", int'(aborted), 0);
        abort = 1'($urandom_range(1, 0));
        @(negedge clk);
        abort = 1'b0;
        check("after_done_cmd_ready", int'(cmd_ready), 1);
        check("done_once", int'(done), 0);
        check("abort_ignored_in_done", int'(aborted), 0);
        fin = 1'b1;
      end else if (cyc > 2000) begin
        check("sweep_timeout", 0, 1);
        fin = 1'b1;
      end
    end
  endtask

  initial begin
    int len;
    int ab_at;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_start = '0;
    cmd_len   = '0;
    cmd_dir   = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
    check("rst_gray", int'(gray_out), 0);
    check("rst_binary", int'(binary_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    ready_prob = 100;
    run_sweep(0, 5, 0, 0);
    run_sweep(1, 3, 1, 0);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run_sweep(14, 4, 0, 0);
    rdy_pat.delete();
    run_sweep(7, 0, 0, 0);
    run_sweep(2, 10, 0, 3);
    run_sweep(5, 1, 0, 0);
    check("post_abort_gray", int'(gray_out), 7);
    run_sweep(15, 3, 0, 0);

    ready_prob = 70;
    for (int i = 0; i < 25; i++) begin
      len   = ($urandom_range(9, 0) == 0) ? 20 + $urandom_range(20, 0) : $urandom_range(12, 0);
      ab_at = ($urandom_range(3, 0) == 0 && len != 0) ? $urandom_range(len, 1) : 0;
      run_sweep($urandom_range((1 << W) - 1, 0), len, $urandom_range(1, 0), ab_at);
    end

    // Reset held for one cycle in the middle of a sweep
    ready_prob = 100;
    cmd_valid = 1'b1;
    cmd_start = W'(3);
    cmd_len   = LW'(10);
    cmd_dir   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_sweep_running", int'(out_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_cmd_ready", int'(cmd_ready), 1);
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_aborted", int'(aborted), 0);
    check("mrst_gray", int'(gray_out), 0);
    check("mrst_binary", int'(binary_out), 0);
    @(negedge clk);
    check("mrst_no_late_done", int'(done), 0);
    check("mrst_no_late_aborted", int'(aborted), 0);
    check("mrst_stays_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
